regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised general-purpose register file for the CPU datapath, successor to the fixed 32x32 design.
- Configurable width and depth, optional hardwired-zero entry 0, and per-byte write enables.
- Two read ports registered on the rising edge, with write-first bypass.
- Sequential clear sweep after reset, so every entry holds a defined value. Sits between decode (read addresses) and writeback (write port).

Parameters:
- DATA_WIDTH, 32, bits per register; must be a multiple of 8, minimum 8.
- ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH entries.
- ZERO_REG0, 1, when 1 entry 0 always reads 0 and writes to it are discarded.
- BYPASS_EN, 1, when 1 a same-cycle write to a read address is forwarded to that read output.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write request, sampled on posedge.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- wr_be  input  DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i].
- rd_addr_1  input  ADDR_WIDTH  read port 1 address.
- rd_addr_2  input  ADDR_WIDTH  read port 2 address.
- rd_data_1  output  DATA_WIDTH  read port 1 data, registered.
- rd_data_2  output  DATA_WIDTH  read port 2 data, registered.
- init_busy  output  1  high while the clear sweep runs; the writer must hold off.

Behaviour:
- Reset: when rst=1 at a posedge, next state is CLEAR, sweep pointer = 0, rd_data_1 = rd_data_2 = 0, init_busy = 1.
- rst asserted mid-sweep or mid-operation restarts the sweep at entry 0.
- States:
  - CLEAR: each cycle writes 0 to entry[ptr], then ptr++. After the cycle that writes entry DEPTH-1, go to RUN; that is DEPTH cycles after rst deasserts.
  - RUN: init_busy = 0. Stays in RUN until the next rst.
- CLEAR rules:
  - we is ignored; no user write lands and nothing is queued.
  - rd_data_1 and rd_data_2 are held at 0.
  - init_busy drops in the first cycle of RUN.
- Write (RUN only):
  - At a posedge with we=1, each byte i with wr_be[i]=1 updates entry[wr_addr] byte i. Bytes with wr_be[i]=0 keep their old value.
  - wr_be all zero means no change.
  - If ZERO_REG0=1 and wr_addr=0, the write is dropped.
- Read (RUN only):
  - At each posedge, rd_data_n <= entry[rd_addr_n]. Latency is 1 cycle from address to data.
  - Reads happen every cycle; there is no enable.
  - If ZERO_REG0=1 and rd_addr_n=0, rd_data_n <= 0 regardless of bypass.
- Bypass:
  - Applies when BYPASS_EN=1, we=1, state is RUN, and rd_addr_n = wr_addr is a writable address.
  - rd_data_n <= merge(entry[rd_addr_n], wr_data, wr_be): the new value per enabled byte, the old value per disabled byte.
  - Result: data written in cycle t is visible on rd_data in cycle t+1 through either path.
  - When BYPASS_EN=0, rd_data_n <= the old entry value; the new value is readable from the following cycle.
- Both read ports may address the same entry; each resolves independently and identically.
- Entry contents are never X after the sweep completes. Out-of-range addresses are not possible, because DEPTH = 2**ADDR_WIDTH.
- No combinational path from any input to any output.

Test Plan:
- Reset clear: assert rst 1 cycle, default params, then sweep -> init_busy=1 for exactly 32 cycles. Afterwards, reading every address 0..31 returns 0x00000000.
- Basic write/read: we=1, wr_addr=5, wr_data=0xDEADBEEF, wr_be=0xF. Next cycle rd_addr_1=5 -> rd_data_1=0xDEADBEEF one cycle later.
- Byte enables: entry 7 = 0x11223344, write 0xAABBCCDD with wr_be=0x5 -> entry 7 reads 0x11BB33DD.
- Bypass: same cycle we=1, wr_addr=9, wr_data=0x12345678, rd_addr_1=rd_addr_2=9 -> both rd_data=0x12345678 next cycle.
  - Repeat with BYPASS_EN=0 -> old value next cycle, then 0x12345678 the cycle after.
- Zero register: write 0xFFFFFFFF to addr 0, then read addr 0 on both ports (including same-cycle bypass) -> 0x00000000.
  - With ZERO_REG0=0 -> 0xFFFFFFFF.
- Reset mid-sweep and write during CLEAR: assert rst at sweep cycle 10 -> init_busy stays 1 for 32 more cycles.
  - A we=1 to addr 3 with 0xCAFEF00D during CLEAR -> addr 3 reads 0 after the sweep.
  - Variant DATA_WIDTH=16, ADDR_WIDTH=3 -> 8-cycle sweep.

Source files
------------

// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: one byte-enabled write port, two registered read ports
// and the clear-sweep busy flag.
interface regfile_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) ();
    logic                    we;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_be;
    logic [ADDR_WIDTH-1:0]   rd_addr_1;
    logic [ADDR_WIDTH-1:0]   rd_addr_2;
    logic [DATA_WIDTH-1:0]   rd_data_1;
    logic [DATA_WIDTH-1:0]   rd_data_2;
    logic                    init_busy;

    modport master (
        output we, wr_addr, wr_data, wr_be, rd_addr_1, rd_addr_2,
        input  rd_data_1, rd_data_2, init_busy
    );

    modport slave (
        input  we, wr_addr, wr_data, wr_be, rd_addr_1, rd_addr_2,
        output rd_data_1, rd_data_2, init_busy
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: byte-enabled write, two registered read ports with
// optional write-first bypass, optional hardwired-zero entry 0, clear sweep after reset.
module regfile_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG0  = 1'b1,
    parameter bit BYPASS_EN  = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    regfile_param_if.slave bus
);
    localparam int          DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data_1;
    logic [DATA_WIDTH-1:0] r_rd_data_2;
    logic [DATA_WIDTH-1:0] w_rd_nxt_1;
    logic [DATA_WIDTH-1:0] w_rd_nxt_2;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                if (r_ptr == '1) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_wr_en = bus.we && !(ZERO_REG0 && (bus.wr_addr == '0));
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    // Byte-wise merge of the write data over the current entry; feeds both the
    // array write and the bypass path so the two always agree.
    always_comb begin
        w_old    = r_mem[bus.wr_addr];
        w_merged = w_old;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (bus.wr_be[i]) begin
                w_merged[8*i +: 8] = bus.wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_rd_nxt_1 = r_mem[bus.rd_addr_1];
        w_rd_nxt_2 = r_mem[bus.rd_addr_2];
        if (BYPASS_EN && w_wr_en && (bus.rd_addr_1 == bus.wr_addr)) begin
            w_rd_nxt_1 = w_merged;
        end
        if (BYPASS_EN && w_wr_en && (bus.rd_addr_2 == bus.wr_addr)) begin
            w_rd_nxt_2 = w_merged;
        end
        if (ZERO_REG0 && (bus.rd_addr_1 == '0)) begin
            w_rd_nxt_1 = '0;
        end
        if (ZERO_REG0 && (bus.rd_addr_2 == '0)) begin
            w_rd_nxt_2 = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_rd_data_1 <= '0;
            r_rd_data_2 <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_mem[r_ptr] <= '0;
            r_ptr        <= r_ptr + 1'b1;
            r_rd_data_1  <= '0;
            r_rd_data_2  <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[bus.wr_addr] <= w_merged;
            end
            r_rd_data_1 <= w_rd_nxt_1;
            r_rd_data_2 <= w_rd_nxt_2;
        end
    end

    assign bus.rd_data_1 = r_rd_data_1;
    assign bus.rd_data_2 = r_rd_data_2;
    assign bus.init_busy = (r_state == ST_CLEAR);
endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default build, a no-bypass/no-zero-reg build sharing
// the same stimulus, and a 16x8 build with its own reset.
module tb_regfile_param;
    logic clk;
    logic rst;
    logic rst_c;
    int   n_cmp;
    int   n_err;
    int   cnt;

    regfile_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifa ();
    regfile_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifb ();
    regfile_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) ifc ();

    regfile_param dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    regfile_param #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .ZERO_REG0  (1'b0),
        .BYPASS_EN  (1'b0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    regfile_param #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (3)
    ) dut_c (
        .clk (clk),
        .rst (rst_c),
        .bus (ifc)
    );

    assign ifb.we        = ifa.we;
    assign ifb.wr_addr   = ifa.wr_addr;
    assign ifb.wr_data   = ifa.wr_data;
    assign ifb.wr_be     = ifa.wr_be;
    assign ifb.rd_addr_1 = ifa.rd_addr_1;
    assign ifb.rd_addr_2 = ifa.rd_addr_2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        ifa.we      = 1'b1;
        ifa.wr_addr = a;
        ifa.wr_data = d;
        ifa.wr_be   = be;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        rst_c = 1'b0;
        ifa.we = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.wr_be = '0;
        ifa.rd_addr_1 = '0; ifa.rd_addr_2 = '0;
        ifc.we = 1'b0; ifc.wr_addr = '0; ifc.wr_data = '0; ifc.wr_be = '0;
        ifc.rd_addr_1 = '0; ifc.rd_addr_2 = '0;
        tick();

        // reset state
        rst = 1'b1;
        tick();
        check("rst_busy_a", ifa.init_busy, 1);
        check("rst_rd1_a", ifa.rd_data_1, 0);
        check("rst_rd2_a", ifa.rd_data_2, 0);
        check("rst_busy_b", ifb.init_busy, 1);

        // write attempt during CLEAR, then reset mid-sweep
        rst = 1'b0;
        wr_a(5'd3, 32'hCAFEF00D, 4'hF);
        ifa.rd_addr_1 = 5'd3;
        repeat (10) tick();
        check("busy_mid_sweep", ifa.init_busy, 1);
        check("rd_held_clear", ifa.rd_data_1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt = 0;
        while (ifa.init_busy && cnt < 100) begin
            tick();
            cnt++;
        end
        check("sweep_len_a", cnt, 32);
        check("busy_b_done", ifb.init_busy, 0);
        ifa.we = 1'b0;

        for (int i = 0; i < 32; i++) begin
            ifa.rd_addr_1 = 5'(i);
            ifa.rd_addr_2 = 5'(31 - i);
            tick();
            check("clear_rd1_a", ifa.rd_data_1, 0);
            check("clear_rd2_a", ifa.rd_data_2, 0);
            check("clear_rd1_b", ifb.rd_data_1, 0);
        end
        ifa.rd_addr_1 = 5'd3;
        tick();
        check("clear_wr_dropped", ifa.rd_data_1, 0);

        // basic write/read
        wr_a(5'd5, 32'hDEADBEEF, 4'hF);
        tick();
        ifa.we = 1'b0;
        ifa.rd_addr_1 = 5'd5;
        tick();
        check("basic_a", ifa.rd_data_1, 32'hDEADBEEF);
        check("basic_b", ifb.rd_data_1, 32'hDEADBEEF);

        // byte enables
        wr_a(5'd7, 32'h11223344, 4'hF);
        tick();
        wr_a(5'd7, 32'hAABBCCDD, 4'h5);
        tick();
        wr_a(5'd7, 32'hFFFFFFFF, 4'h0);
        tick();
        ifa.we = 1'b0;
        ifa.rd_addr_1 = 5'd7;
        tick();
        check("byte_en_a", ifa.rd_data_1, 32'h11BB33DD);
        check("byte_en_b", ifb.rd_data_1, 32'h11BB33DD);

        // bypass vs no bypass
        wr_a(5'd9, 32'h12345678, 4'hF);
        ifa.rd_addr_1 = 5'd9;
        ifa.rd_addr_2 = 5'd9;
        tick();
        ifa.we = 1'b0;
        check("byp_rd1_a", ifa.rd_data_1, 32'h12345678);
        check("byp_rd2_a", ifa.rd_data_2, 32'h12345678);
        check("nobyp_rd1_b", ifb.rd_data_1, 32'h00000000);
        check("nobyp_rd2_b", ifb.rd_data_2, 32'h00000000);
        tick();
        check("nobyp_next_b", ifb.rd_data_1, 32'h12345678);
        check("byp_next_a", ifa.rd_data_2, 32'h12345678);

        // partial-byte bypass merge
        wr_a(5'd9, 32'hAABBCCDD, 4'h3);
        tick();
        ifa.we = 1'b0;
        check("byp_merge_a", ifa.rd_data_1, 32'h1234CCDD);
        check("nobyp_merge_b", ifb.rd_data_1, 32'h12345678);
        tick();
        check("merge_stored_b", ifb.rd_data_2, 32'h1234CCDD);

        // zero register
        wr_a(5'd0, 32'hFFFFFFFF, 4'hF);
        ifa.rd_addr_1 = 5'd0;
        ifa.rd_addr_2 = 5'd0;
        tick();
        ifa.we = 1'b0;
        check("zero_byp_rd1_a", ifa.rd_data_1, 0);
        check("zero_byp_rd2_a", ifa.rd_data_2, 0);
        check("nozero_old_b", ifb.rd_data_1, 0);
        tick();
        check("zero_rd1_a", ifa.rd_data_1, 0);
        check("nozero_rd1_b", ifb.rd_data_1, 32'hFFFFFFFF);
        check("nozero_rd2_b", ifb.rd_data_2, 32'hFFFFFFFF);

        // reset mid-operation wipes contents
        rst = 1'b1;
        tick();
        check("rerst_rd_a", ifa.rd_data_1, 0);
        rst = 1'b0;
        cnt = 0;
        while (ifa.init_busy && cnt < 100) begin
            tick();
            cnt++;
        end
        check("resweep_len_a", cnt, 32);
        ifa.rd_addr_1 = 5'd5;
        ifa.rd_addr_2 = 5'd0;
        tick();
        check("rerst_wipe_a", ifa.rd_data_1, 0);
        check("rerst_wipe_b", ifb.rd_data_2, 0);

        // 16-bit x 8-entry variant
        rst_c = 1'b1;
        tick();
        check("rst_busy_c", ifc.init_busy, 1);
        rst_c = 1'b0;
        cnt = 0;
        while (ifc.init_busy && cnt < 100) begin
            tick();
            cnt++;
        end
        check("sweep_len_c", cnt, 8);
        ifc.we = 1'b1; ifc.wr_addr = 3'd2; ifc.wr_data = 16'hBEEF; ifc.wr_be = 2'b01;
        tick();
        ifc.wr_data = 16'h1234; ifc.wr_be = 2'b10;
        tick();
        ifc.we = 1'b0;
        ifc.rd_addr_1 = 3'd2;
        tick();
        check("byte_en_c", ifc.rd_data_1, 32'h000012EF);
        ifc.we = 1'b1; ifc.wr_data = 16'hA5A5; ifc.wr_be = 2'b10;
        ifc.rd_addr_2 = 3'd0;
        tick();
        check("byp_merge_c", ifc.rd_data_1, 32'h0000A5EF);
        check("zero_c", ifc.rd_data_2, 0);
        ifc.wr_addr = 3'd7; ifc.wr_data = 16'hFFFF; ifc.wr_be = 2'b11;
        ifc.rd_addr_1 = 3'd7;
        tick();
        ifc.we = 1'b0;
        check("top_entry_c", ifc.rd_data_1, 32'h0000FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
